// File: rtl/relu_collect_pkg.sv
// Shared types and constants for the ReLU result collector: read FSM states,
// bank count and the index-width helper.
package relu_collect_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_e;

  // Width of an element index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relu_collect_bank.sv
// One activation-vector bank: element storage, full flag and zero-on-release.
// Running max/argmax tracking is present only when RELU_COLLECT_ARGMAX_EN is defined.
module relu_collect_bank
  import relu_collect_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int VECTOR_LEN = 4,
  parameter int IDX_W      = idx_width(VECTOR_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_last_i,
  input  logic                  release_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o
`ifdef RELU_COLLECT_ARGMAX_EN
  ,
  output logic [IDX_W-1:0]      argmax_o
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [VECTOR_LEN];
  logic [DATA_WIDTH-1:0] mem_d [VECTOR_LEN];
  logic                  full_q, full_d;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    mem_d  = mem_q;
    full_d = full_q;
    if (release_i) begin
      for (int i = 0; i < VECTOR_LEN; i++) begin
        mem_d[i] = '0;
      end
      full_d = 1'b0;
    end else if (wr_en_i) begin
      mem_d[wr_idx_i] = wr_data_i;
      if (wr_last_i) begin
        full_d = 1'b1;
      end
    end
  end

  // NOTE: storage is reset element by element on purpose: unwritten positions
  // of a vector must read back as zero, which plain RAM could not guarantee.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VECTOR_LEN; i++) begin
        mem_q[i] <= '0;
      end
      full_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q  <= mem_d;
      full_q <= full_d;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign full_o    = full_q;

`ifdef RELU_COLLECT_ARGMAX_EN
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0]      argmax_q, argmax_d;

  // Strict compare keeps the first-written maximum on ties.
  always_comb begin
    max_d    = max_q;
    argmax_d = argmax_q;
    if (release_i) begin
      max_d    = '0;
      argmax_d = '0;
    end else if (wr_en_i && (wr_data_i > max_q)) begin
      max_d    = wr_data_i;
      argmax_d = wr_idx_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q    <= '0;
      argmax_q <= '0;
    end else begin
      max_q    <= max_d;
      argmax_q <= argmax_d;
    end
  end

  assign argmax_o = argmax_q;
`endif

endmodule

// File: rtl/relu_result_collector.sv
// Collects ReLU output elements into two ping-pong vector banks and streams each
// completed vector over valid/ready. Define RELU_COLLECT_ARGMAX_EN to add out_argmax.
module relu_result_collector
  import relu_collect_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int VECTOR_LEN = 4,
  localparam int IDX_W      = idx_width(VECTOR_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_enable,
  input  logic [DATA_WIDTH-1:0] in_index,
  input  logic [DATA_WIDTH-1:0] in_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  overflow,
  output logic                  index_error
`ifdef RELU_COLLECT_ARGMAX_EN
  ,
  output logic [IDX_W-1:0]      out_argmax
`endif
);

  localparam logic [DATA_WIDTH-1:0] LEN_D    = DATA_WIDTH'(VECTOR_LEN);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(VECTOR_LEN - 1);

  rd_state_e        state_q, state_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             rd_bank_q, rd_bank_d;
  logic             wr_bank_q, wr_bank_d;
  logic             overflow_q, overflow_d;
  logic             index_error_q, index_error_d;

  logic                  idx_bad, wr_accept, wr_last, rd_release;
  logic [IDX_W-1:0]      wr_idx;
  logic [NUM_BANKS-1:0]  bank_full;
  logic [DATA_WIDTH-1:0] bank_rd_data [NUM_BANKS];
`ifdef RELU_COLLECT_ARGMAX_EN
  logic [IDX_W-1:0]      bank_argmax [NUM_BANKS];
`endif

  // Write side: a bad index is rejected before the full check is considered.
  assign idx_bad   = in_enable && (in_index >= LEN_D);
  assign wr_idx    = in_index[IDX_W-1:0];
  assign wr_accept = in_enable && !idx_bad && !bank_full[wr_bank_q];
  assign wr_last   = wr_accept && (wr_idx == LAST_IDX);

  always_comb begin
    wr_bank_d     = wr_last ? ~wr_bank_q : wr_bank_q;
    overflow_d    = overflow_q || (in_enable && !idx_bad && bank_full[wr_bank_q]);
    index_error_d = index_error_q || idx_bad;
  end

  // Read FSM next state; a bank is released on acceptance of its last beat.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_bank_d  = rd_bank_q;
    rd_release = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bank_full[rd_bank_q]) begin
          state_d  = ST_STREAM;
          rd_ptr_d = '0;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (rd_ptr_q == LAST_IDX) begin
            rd_release = 1'b1;
            rd_bank_d  = ~rd_bank_q;
            state_d    = ST_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rd_ptr_q      <= '0;
      rd_bank_q     <= 1'b0;
      wr_bank_q     <= 1'b0;
      overflow_q    <= 1'b0;
      index_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_bank_q     <= rd_bank_d;
      wr_bank_q     <= wr_bank_d;
      overflow_q    <= overflow_d;
      index_error_q <= index_error_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    relu_collect_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .VECTOR_LEN(VECTOR_LEN),
      .IDX_W     (IDX_W)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en_i  (wr_accept && (int'(wr_bank_q) == b)),
      .wr_idx_i (wr_idx),
      .wr_data_i(in_value),
      .wr_last_i(wr_last),
      .release_i(rd_release && (int'(rd_bank_q) == b)),
      .rd_idx_i (rd_ptr_q),
      .rd_data_o(bank_rd_data[b]),
      .full_o   (bank_full[b])
`ifdef RELU_COLLECT_ARGMAX_EN
      ,
      .argmax_o (bank_argmax[b])
`endif
    );
  end

  // Outputs are decoded from registers only; out_ready never reaches them.
  assign out_valid   = (state_q == ST_STREAM);
  assign out_data    = out_valid ? bank_rd_data[rd_bank_q] : '0;
  assign out_index   = out_valid ? rd_ptr_q : '0;
  assign out_last    = out_valid && (rd_ptr_q == LAST_IDX);
  assign overflow    = overflow_q;
  assign index_error = index_error_q;
`ifdef RELU_COLLECT_ARGMAX_EN
  assign out_argmax  = out_last ? bank_argmax[rd_bank_q] : '0;
`endif

endmodule

// File: tb/tb_relu_result_collector.sv
// Directed self-checking bench for relu_result_collector (VECTOR_LEN=4, DATA_WIDTH=32).
// Checks out_argmax as well when RELU_COLLECT_ARGMAX_EN is defined.
module tb_relu_result_collector;

  localparam int DW = 32;
  localparam int VL = 4;
  localparam int IW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_enable;
  logic [DW-1:0] in_index;
  logic [DW-1:0] in_value;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          overflow;
  logic          index_error;
`ifdef RELU_COLLECT_ARGMAX_EN
  logic [IW-1:0] out_argmax;
`endif

  int n_checks = 0;
  int n_errors = 0;

  relu_result_collector #(.DATA_WIDTH(DW), .VECTOR_LEN(VL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_enable  (in_enable),
    .in_index   (in_index),
    .in_value   (in_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .overflow   (overflow),
    .index_error(index_error)
`ifdef RELU_COLLECT_ARGMAX_EN
    ,
    .out_argmax (out_argmax)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    in_enable = 1'b0;
    in_index  = '0;
    in_value  = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_elem(input int idx, input int val);
    @(negedge clk);
    in_enable = 1'b1;
    in_index  = DW'(idx);
    in_value  = DW'(val);
    @(posedge clk);
    #1;
    in_enable = 1'b0;
  endtask

  task automatic write_vec(input int v0, input int v1, input int v2, input int v3);
    write_elem(0, v0);
    write_elem(1, v1);
    write_elem(2, v2);
    write_elem(3, v3);
  endtask

  // Advances at least one falling edge; a timeout counts as a failed check.
  task automatic wait_valid(input string tag);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    check({tag, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic check_beat(input string tag, input int i, input int d, input int am);
    check($sformatf("%s_valid%0d", tag, i), 64'(out_valid), 64'd1);
    check($sformatf("%s_data%0d", tag, i), 64'(out_data), 64'(d));
    check($sformatf("%s_idx%0d", tag, i), 64'(out_index), 64'(i));
    check($sformatf("%s_last%0d", tag, i), 64'(out_last), (i == VL - 1) ? 64'd1 : 64'd0);
`ifdef RELU_COLLECT_ARGMAX_EN
    check($sformatf("%s_argmax%0d", tag, i), 64'(out_argmax), (i == VL - 1) ? 64'(am) : 64'd0);
`endif
  endtask

  // Expects beat 0 on display now and out_ready held high for the whole vector.
  task automatic read_vec(input string tag, input int v0, input int v1, input int v2,
                          input int v3, input int am);
    int exp_v[4];
    exp_v = '{v0, v1, v2, v3};
    for (int i = 0; i < VL; i++) begin
      if (i > 0) @(negedge clk);
      check_beat(tag, i, exp_v[i], am);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_dut();
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_idxerr", 64'(index_error), 64'd0);

    // 1: basic vector and write-to-valid latency
    out_ready = 1'b1;
    write_vec(5, 0, 7, 2);
    @(negedge clk);
    check("t1_lat_n1", 64'(out_valid), 64'd0);
    @(negedge clk);
    read_vec("t1", 5, 0, 7, 2, 2);
    @(negedge clk);
    check("t1_after", 64'(out_valid), 64'd0);

    // 2: backpressure, both banks fill, ninth element overflows
    out_ready = 1'b0;
    write_vec(10, 20, 30, 40);
    check("t2_ovf_a", 64'(overflow), 64'd0);
    write_vec(11, 3, 25, 4);
    @(negedge clk);
    check("t2_ovf_b", 64'(overflow), 64'd0);
    write_elem(0, 99);
    @(negedge clk);
    check("t2_ovf_set", 64'(overflow), 64'd1);
    repeat (2) @(negedge clk);
    check("t2_hold_valid", 64'(out_valid), 64'd1);
    check("t2_hold_data", 64'(out_data), 64'd10);
    check("t2_hold_idx", 64'(out_index), 64'd0);
    out_ready = 1'b1;
    read_vec("t2a", 10, 20, 30, 40, 3);
    @(negedge clk);
    check("t2_gap", 64'(out_valid), 64'd0);
    @(negedge clk);
    read_vec("t2b", 11, 3, 25, 4, 2);
    @(negedge clk);
    check("t2_end", 64'(out_valid), 64'd0);

    // 3: out-of-range index is dropped
    write_elem(4, 9);
    @(negedge clk);
    check("t3_idxerr", 64'(index_error), 64'd1);
    repeat (3) @(negedge clk);
    check("t3_valid", 64'(out_valid), 64'd0);

    // 4: missing elements read zero; duplicates keep the last write
    write_elem(0, 9);
    write_elem(2, 8);
    write_elem(3, 7);
    wait_valid("t4a");
    read_vec("t4a", 9, 0, 8, 7, 0);
    write_vec(1, 2, 3, 4);
    wait_valid("t4b");
    read_vec("t4b", 1, 2, 3, 4, 3);
    write_elem(1, 4);
    write_elem(1, 6);
    write_elem(3, 5);
    wait_valid("t4c");
    read_vec("t4c", 0, 6, 0, 5, 1);

    // 5: asynchronous reset in the middle of a vector
    check("t5_ovf_pre", 64'(overflow), 64'd1);
    write_vec(1, 2, 3, 4);
    wait_valid("t5");
    check_beat("t5", 0, 1, 0);
    @(negedge clk);
    check_beat("t5", 1, 2, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_ovf", 64'(overflow), 64'd0);
    check("t5_rst_idxerr", 64'(index_error), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_post_valid", 64'(out_valid), 64'd0);
    write_elem(3, 8);
    wait_valid("t5b");
    read_vec("t5b", 0, 0, 0, 8, 3);

    // 6: last beat of bank 0 accepted on the edge that completes bank 1
    reset_dut();
    write_vec(21, 22, 23, 24);
    write_elem(0, 31);
    write_elem(1, 32);
    write_elem(2, 33);
    wait_valid("t6a");
    check_beat("t6a", 0, 21, 3);
    out_ready = 1'b1;
    @(negedge clk);
    check_beat("t6a", 1, 22, 3);
    @(negedge clk);
    check_beat("t6a", 2, 23, 3);
    @(negedge clk);
    check_beat("t6a", 3, 24, 3);
    in_enable = 1'b1;
    in_index  = DW'(3);
    in_value  = DW'(34);
    @(posedge clk);
    #1 in_enable = 1'b0;
    @(negedge clk);
    check("t6_gap", 64'(out_valid), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    read_vec("t6b", 31, 32, 33, 34, 3);
    write_vec(41, 44, 42, 43);
    wait_valid("t6c");
    read_vec("t6c", 41, 44, 42, 43, 1);
    @(negedge clk);
    check("t6_ovf_end", 64'(overflow), 64'd0);
    check("t6_idxerr_end", 64'(index_error), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
